// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- parametrised raster timing generator.
//
// A pixel counter (h_cnt) and a line counter (v_cnt) walk the raster in
// the order SYNC, BP, ACTIVE, FP on each axis, with count 0 being the first
// sync cycle/line. All outputs are registered decodes of the counters, so
// the pins show position (h,v) one pclk after the counters held it.
//
// Ports:
//   pclk    pixel clock, rising edge
//   rstn    asynchronous active-low reset
//   en      run enable; counters advance and outputs update only when high
//   resync  (VGA_TIMING_RESYNC_EN only) load counters to (0,0), beats en
//   hs, vs  sync pulses, active level set by HS_POL / VS_POL
//   hen     horizontal active region
//   ven     vertical active region
//   de      hen & ven
//   x, y    active pixel column / active line, 0 outside the active region
//   sof     one-cycle strobe when outputs show position (0,0)
//   eol     one-cycle strobe on the last active pixel of an active line
//
// Optional feature macro: VGA_TIMING_RESYNC_EN (adds the resync input).
module vga_timing_gen #(
  parameter int unsigned H_SYNC   = 120,
  parameter int unsigned H_BP     = 64,
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 56,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 23,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 37,
  parameter int unsigned HS_POL   = 1,
  parameter int unsigned VS_POL   = 1,
  parameter int unsigned CW       = 12
) (
  input  logic          pclk,
  input  logic          rstn,
  input  logic          en,
`ifdef VGA_TIMING_RESYNC_EN
  input  logic          resync,
`endif
  output logic          hs,
  output logic          vs,
  output logic          hen,
  output logic          ven,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          sof,
  output logic          eol
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_END  = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_END  = CW'(V_SYNC);
  localparam logic [CW-1:0] H_ACT_START = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] V_ACT_START = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] H_ACT_END   = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_END   = CW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [CW-1:0] H_ACT_LAST  = CW'(H_SYNC + H_BP + H_ACTIVE - 1);

  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  logic [CW-1:0] h_cnt, v_cnt;
  logic [CW-1:0] h_next, v_next;
  logic          h_wrap;
  logic          load_zero;

  logic          hs_d, vs_d, hen_d, ven_d, de_d, sof_d, eol_d;
  logic [CW-1:0] x_d, y_d;

`ifdef VGA_TIMING_RESYNC_EN
  assign load_zero = resync;
`else
  assign load_zero = 1'b0;
`endif

  // Counter advance: line counter steps only on the pixel-counter wrap.
  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    h_next = h_wrap ? '0 : h_cnt + 1'b1;
    v_next = v_cnt;
    if (h_wrap) begin
      v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (load_zero) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      h_cnt <= h_next;
      v_cnt <= v_next;
    end
  end

  // Decode of the current counter position; registered below.
  always_comb begin
    hs_d  = (h_cnt < H_SYNC_END) ? HS_ACT : ~HS_ACT;
    vs_d  = (v_cnt < V_SYNC_END) ? VS_ACT : ~VS_ACT;
    hen_d = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END);
    ven_d = (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
    de_d  = hen_d && ven_d;
    x_d   = hen_d ? (h_cnt - H_ACT_START) : '0;
    y_d   = ven_d ? (v_cnt - V_ACT_START) : '0;
    sof_d = (h_cnt == '0) && (v_cnt == '0);
    eol_d = de_d && (h_cnt == H_ACT_LAST);
  end

  // While paused every output holds, except the strobes which drop so a
  // held position cannot emit a second sof/eol.
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      hs  <= ~HS_ACT;
      vs  <= ~VS_ACT;
      hen <= 1'b0;
      ven <= 1'b0;
      de  <= 1'b0;
      x   <= '0;
      y   <= '0;
      sof <= 1'b0;
      eol <= 1'b0;
    end else if (en) begin
      hs  <= hs_d;
      vs  <= vs_d;
      hen <= hen_d;
      ven <= ven_d;
      de  <= de_d;
      x   <= x_d;
      y   <= y_d;
      sof <= sof_d;
      eol <= eol_d;
    end else begin
      sof <= 1'b0;
      eol <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using small raster parameters
// (H 2/2/4/2, V 1/1/3/1, negative sync polarity). A position-based
// reference model predicts every output on every clock.
module tb_vga_timing_gen;

  localparam int unsigned HS  = 2;
  localparam int unsigned HB  = 2;
  localparam int unsigned HA  = 4;
  localparam int unsigned HF  = 2;
  localparam int unsigned VS  = 1;
  localparam int unsigned VB  = 1;
  localparam int unsigned VA  = 3;
  localparam int unsigned VF  = 1;
  localparam int unsigned HSP = 0;
  localparam int unsigned VSP = 0;
  localparam int unsigned CW  = 4;
  localparam int unsigned HT  = HS + HB + HA + HF;
  localparam int unsigned VT  = VS + VB + VA + VF;
  localparam bit HS_ACT = (HSP != 0);
  localparam bit VS_ACT = (VSP != 0);

  logic pclk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b0;
  logic resync = 1'b0;
  logic hs, vs, hen, ven, de, sof, eol;
  logic [CW-1:0] x, y;

  int checks = 0;
  int errors = 0;

  // Reference model: linear raster position plus predicted outputs.
  int pos;
  logic e_hs, e_vs, e_hen, e_ven, e_de, e_sof, e_eol;
  int e_x, e_y;
  logic [2*CW+6:0] act, exp_v;

  always #5 pclk = ~pclk;

  vga_timing_gen #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
    .HS_POL(HSP), .VS_POL(VSP), .CW(CW)
  ) dut (
    .pclk(pclk),
    .rstn(rstn),
    .en(en),
`ifdef VGA_TIMING_RESYNC_EN
    .resync(resync),
`endif
    .hs(hs),
    .vs(vs),
    .hen(hen),
    .ven(ven),
    .de(de),
    .x(x),
    .y(y),
    .sof(sof),
    .eol(eol)
  );

  initial begin
    assert (HS >= 1 && HB >= 1 && HA >= 1 && HF >= 1);
    assert (VS >= 1 && VB >= 1 && VA >= 1 && VF >= 1);
    assert ((1 << CW) >= HT && (1 << CW) >= VT);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    pos   = 0;
    e_hs  = !HS_ACT;
    e_vs  = !VS_ACT;
    e_hen = 0; e_ven = 0; e_de = 0; e_sof = 0; e_eol = 0;
    e_x   = 0; e_y = 0;
  endtask

  task automatic model_edge(input logic en_v, input logic rs_v);
    int h, v;
    if (!rstn) begin
      model_reset();
      return;
    end
    h = pos % HT;
    v = pos / HT;
    if (en_v) begin
      e_hs  = (h < HS) ? HS_ACT : !HS_ACT;
      e_vs  = (v < VS) ? VS_ACT : !VS_ACT;
      e_hen = (h >= HS + HB) && (h < HS + HB + HA);
      e_ven = (v >= VS + VB) && (v < VS + VB + VA);
      e_de  = e_hen && e_ven;
      e_x   = e_hen ? h - (HS + HB) : 0;
      e_y   = e_ven ? v - (VS + VB) : 0;
      e_sof = (pos == 0);
      e_eol = e_de && (e_x == HA - 1);
    end else begin
      e_sof = 0;
      e_eol = 0;
    end
    if (rs_v) pos = 0;
    else if (en_v) pos = (pos + 1) % (HT * VT);
  endtask

  // One clock: drive inputs, advance model, compare every output.
  task automatic tick(input logic en_v, input logic rs_v);
    en = en_v;
    resync = rs_v;
    @(posedge pclk);
    model_edge(en_v, rs_v);
    #1;
    act   = {hs, vs, hen, ven, de, x, y, sof, eol};
    exp_v = {e_hs, e_vs, e_hen, e_ven, e_de, CW'(e_x), CW'(e_y), e_sof, e_eol};
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL model_cmp t=%0t {hs,vs,hen,ven,de,x,y,sof,eol} got %h want %h",
               $time, act, exp_v);
    end
  endtask

  task automatic test_reset();
    rstn = 0; en = 0; resync = 0;
    model_reset();
    repeat (2) @(posedge pclk);
    #1;
    checks++;
    if ({hs, vs, hen, ven, de, x, y, sof, eol} !== {!HS_ACT, !VS_ACT, 3'b000, CW'(0), CW'(0), 2'b00}) begin
      errors++;
      $display("FAIL reset_vals got %b%b%b%b%b x=%0d y=%0d sof=%b eol=%b",
               hs, vs, hen, ven, de, x, y, sof, eol);
    end
    rstn = 1;
    tick(0, 0);
    tick(0, 0);
  endtask

  task automatic test_free_run();
    int n, hs_n, de_n, eol_n;
    int ys[3];
    tick(1, 0);
    checks++;
    if (sof !== 1'b1 || hs !== HS_ACT) begin
      errors++;
      $display("FAIL first_sof got sof=%b hs=%b want sof=1 hs=%b", sof, hs, HS_ACT);
    end
    n = 0; hs_n = 0; de_n = 0; eol_n = 0;
    while (n < 200) begin
      tick(1, 0);
      n++;
      if (hs === HS_ACT) hs_n++;
      if (de === 1'b1) de_n++;
      if (eol === 1'b1) begin
        if (eol_n < 3) ys[eol_n] = int'(y);
        eol_n++;
      end
      if (sof === 1'b1) break;
    end
    checks++;
    if (n != 60) begin
      errors++;
      $display("FAIL frame_len got %0d want 60", n);
    end
    checks++;
    if (hs_n != 12) begin
      errors++;
      $display("FAIL hs_active_count got %0d want 12", hs_n);
    end
    checks++;
    if (de_n != 12) begin
      errors++;
      $display("FAIL de_count got %0d want 12", de_n);
    end
    checks++;
    if (eol_n != 3) begin
      errors++;
      $display("FAIL eol_count got %0d want 3", eol_n);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (eol_n > i && ys[i] != i) begin
        errors++;
        $display("FAIL eol_y%0d got %0d want %0d", i, ys[i], i);
      end
    end
  endtask

  // Starts right after a sof tick.
  task automatic test_enable_pause();
    int n;
    n = 0;
    while (n < 100) begin
      tick(1, 0);
      n++;
      if (de === 1'b1 && x == 3) break;
    end
    for (int i = 0; i < 7; i++) begin
      tick(0, 0);
      n++;
      checks++;
      if (x !== CW'(3) || de !== 1'b1 || sof !== 1'b0 || eol !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold got x=%0d de=%b sof=%b eol=%b want x=3 de=1 sof=0 eol=0",
                 x, de, sof, eol);
      end
    end
    tick(1, 0);
    n++;
    checks++;
    if (x !== CW'(4) && HA > 4) begin
      errors++;
      $display("FAIL resume_x got %0d want 4", x);
    end else if (HA == 4 && x !== CW'(0)) begin
      errors++;
      $display("FAIL resume_x got %0d want 0 (line exhausted)", x);
    end
    while (n < 200) begin
      tick(1, 0);
      n++;
      if (sof === 1'b1) break;
    end
    checks++;
    if (n != 67) begin
      errors++;
      $display("FAIL paused_frame_len got %0d want 67", n);
    end
  endtask

  task automatic test_random_enable();
    for (int i = 0; i < 300; i++) tick(($urandom_range(0, 3) != 0), 0);
  endtask

  task automatic test_reset_mid_line();
    int n;
    n = 0;
    while (n < 200) begin
      tick(1, 0);
      n++;
      if (de === 1'b1 && x == 2) break;
    end
    #2;
    rstn = 0;
    model_reset();
    #1;
    checks++;
    if ({hs, vs, hen, ven, de, x, y, sof, eol} !== {!HS_ACT, !VS_ACT, 3'b000, CW'(0), CW'(0), 2'b00}) begin
      errors++;
      $display("FAIL async_reset got %b%b%b%b%b x=%0d y=%0d sof=%b eol=%b",
               hs, vs, hen, ven, de, x, y, sof, eol);
    end
    tick(1, 0);
    tick(1, 0);
    rstn = 1;
    tick(1, 0);
    checks++;
    if (sof !== 1'b1) begin
      errors++;
      $display("FAIL sof_after_reset got %b want 1", sof);
    end
    n = 0;
    while (n < 200) begin
      tick(1, 0);
      n++;
      if (sof === 1'b1) break;
    end
    checks++;
    if (n != 60) begin
      errors++;
      $display("FAIL frame_len_after_reset got %0d want 60", n);
    end
  endtask

`ifdef VGA_TIMING_RESYNC_EN
  task automatic test_resync();
    int n;
    n = int'($urandom_range(5, 100));
    for (int i = 0; i < n; i++) tick(1, 0);
    tick(1, 1);
    tick(1, 0);
    checks++;
    if (sof !== 1'b1 || hs !== HS_ACT) begin
      errors++;
      $display("FAIL resync_sof got sof=%b hs=%b want sof=1 hs=%b", sof, hs, HS_ACT);
    end
    n = 0;
    while (n < 200) begin
      tick(1, 0);
      n++;
      if (sof === 1'b1) break;
    end
    checks++;
    if (n != 60) begin
      errors++;
      $display("FAIL resync_frame_len got %0d want 60", n);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_enable_pause();
    test_random_enable();
    test_reset_mid_line();
`ifdef VGA_TIMING_RESYNC_EN
    test_resync();
`endif
    test_random_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
